// File: rtl/dda_defs.sv
// Shared definitions for the timer controller slice.
//   NB_SW    : width of the switch-style configuration bus to the period counter
//   state_e  : controller FSM encodings (IDLE / RUN / PAUSE)
//   rate_e   : period-select codes, shortest to longest
package dda_defs;

    localparam int NB_SW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        RATE_SHORTEST = 2'b00,
        RATE_SHORT    = 2'b01,
        RATE_LONG     = 2'b10,
        RATE_LONGEST  = 2'b11
    } rate_e;

endpackage

// File: rtl/timer_ctrl_edge_det.sv
// Rising-edge detector with a registered history bit.
//   clock   : system clock
//   i_reset : synchronous active-high reset, clears the history
//   i_sig   : level input
//   o_edge  : high while i_sig is 1 and was 0 at the previous posedge
// The history clears to 0 under reset, so a level already high when reset
// releases is reported as an edge on the first cycle afterwards.
module edge_det (
    input  logic clock,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_edge
);

    logic prev_q;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= i_sig;
        end
    end

    assign o_edge = i_sig & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: start/stop/pause FSM driving an external period counter
// and counting its ticks, with optional one-shot completion.
//   clock, i_reset        : clock and synchronous active-high reset
//   i_start/i_stop/i_pause: level requests, acted on at their rising edges
//   i_rate, i_oneshot,
//   i_nticks              : configuration, latched on a start edge in IDLE
//   i_valid               : periodic tick from the period counter
//   o_sw                  : {latched rate, count enable} to the period counter
//   o_cnt_reset           : one-cycle clear pulse to the period counter
//   o_busy                : high in RUN or PAUSE
//   o_done                : one-cycle pulse on one-shot completion
//   o_ticks               : ticks counted since the last start
module timer_ctrl
    import dda_defs::*;
#(
    parameter int NB_SW    = dda_defs::NB_SW,
    parameter int NB_TICKS = 8
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_pause,
    input  logic [1:0]          i_rate,
    input  logic                i_oneshot,
    input  logic [NB_TICKS-1:0] i_nticks,
    input  logic                i_valid,
    output logic [NB_SW-1:0]    o_sw,
    output logic                o_cnt_reset,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_TICKS-1:0] o_ticks
);

    logic start_e, stop_e, pause_e, valid_e;

    edge_det u_start_det (.clock(clock), .i_reset(i_reset), .i_sig(i_start), .o_edge(start_e));
    edge_det u_stop_det  (.clock(clock), .i_reset(i_reset), .i_sig(i_stop),  .o_edge(stop_e));
    edge_det u_pause_det (.clock(clock), .i_reset(i_reset), .i_sig(i_pause), .o_edge(pause_e));
    edge_det u_valid_det (.clock(clock), .i_reset(i_reset), .i_sig(i_valid), .o_edge(valid_e));

    state_e                state_q, state_d;
    logic [1:0]            rate_q, rate_d;
    logic                  oneshot_q, oneshot_d;
    logic [NB_TICKS-1:0]   nticks_q, nticks_d;
    logic [NB_TICKS-1:0]   ticks_q, ticks_d;
    logic [NB_SW-1:0]      sw_q, sw_d;
    logic                  cnt_reset_q, cnt_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [NB_TICKS-1:0]   ticks_inc;
    logic                  final_tick;

    assign ticks_inc = ticks_q + NB_TICKS'(1);

    // A zero target means "never complete", i.e. continuous counting.
    assign final_tick = valid_e && oneshot_q && (nticks_q != '0) && (ticks_inc == nticks_q);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        oneshot_d   = oneshot_q;
        nticks_d    = nticks_q;
        ticks_d     = ticks_q;
        cnt_reset_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Pause and stop edges are meaningless here and fall through.
                if (start_e) begin
                    state_d     = ST_RUN;
                    rate_d      = i_rate;
                    oneshot_d   = i_oneshot;
                    nticks_d    = i_nticks;
                    ticks_d     = '0;
                    cnt_reset_d = 1'b1;
                end
            end
            ST_RUN: begin
                // The tick is counted even when a stop arrives on the same
                // edge; the stop only suppresses the completion pulse.
                if (valid_e) begin
                    ticks_d = ticks_inc;
                end
                if (stop_e) begin
                    state_d = ST_IDLE;
                end else if (final_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (pause_e) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop_e) begin
                    state_d = ST_IDLE;
                end else if (pause_e) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        sw_d     = '0;
        sw_d[0]  = (state_d == ST_RUN);
        sw_d[2:1] = rate_d;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            rate_q      <= '0;
            oneshot_q   <= 1'b0;
            nticks_q    <= '0;
            ticks_q     <= '0;
            sw_q        <= '0;
            cnt_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rate_q      <= rate_d;
            oneshot_q   <= oneshot_d;
            nticks_q    <= nticks_d;
            ticks_q     <= ticks_d;
            sw_q        <= sw_d;
            cnt_reset_q <= cnt_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_sw        = sw_q;
    assign o_cnt_reset = cnt_reset_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_ticks     = ticks_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl: each task drives one scenario and
// checks outputs #1 after the active clock edge.
module tb_timer_ctrl;

    localparam int NB_SW    = 3;
    localparam int NB_TICKS = 8;

    logic                clock;
    logic                i_reset;
    logic                i_start, i_stop, i_pause;
    logic [1:0]          i_rate;
    logic                i_oneshot;
    logic [NB_TICKS-1:0] i_nticks;
    logic                i_valid;
    logic [NB_SW-1:0]    o_sw;
    logic                o_cnt_reset, o_busy, o_done;
    logic [NB_TICKS-1:0] o_ticks;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int crst_cnt = 0;

    timer_ctrl #(.NB_SW(NB_SW), .NB_TICKS(NB_TICKS)) dut (
        .clock(clock), .i_reset(i_reset),
        .i_start(i_start), .i_stop(i_stop), .i_pause(i_pause),
        .i_rate(i_rate), .i_oneshot(i_oneshot), .i_nticks(i_nticks),
        .i_valid(i_valid),
        .o_sw(o_sw), .o_cnt_reset(o_cnt_reset), .o_busy(o_busy),
        .o_done(o_done), .o_ticks(o_ticks)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (o_done === 1'b1)      done_cnt = done_cnt + 1;
        if (o_cnt_reset === 1'b1) crst_cnt = crst_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=2ms", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        i_valid = 1'b1; step();
        i_valid = 1'b0; step();
    endtask

    task automatic do_stop();
        i_stop = 1'b1; step();
        i_stop = 1'b0; step();
    endtask

    task automatic test_reset();
        i_reset = 1'b1; step(); step();
        total++;
        if ({o_sw, o_cnt_reset, o_busy, o_done, o_ticks} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got sw=%b crst=%b busy=%b done=%b ticks=%0d want all 0",
                     o_sw, o_cnt_reset, o_busy, o_done, o_ticks);
        end
        i_reset = 1'b0; step();
    endtask

    task automatic test_oneshot();
        int d0, c0;
        d0 = done_cnt; c0 = crst_cnt;
        i_rate = 2'b01; i_oneshot = 1'b1; i_nticks = 8'd3; i_start = 1'b1;
        step();
        total++;
        if (o_sw !== 3'b011 || o_cnt_reset !== 1'b1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_start: got sw=%b crst=%b busy=%b want sw=011 crst=1 busy=1",
                     o_sw, o_cnt_reset, o_busy);
        end
        i_start = 1'b0;
        // Configuration changes while running must be ignored.
        i_rate = 2'b11; i_nticks = 8'd9; i_oneshot = 1'b0;
        step();
        total++;
        if (o_cnt_reset !== 1'b0 || o_sw !== 3'b011) begin
            bad++;
            $display("FAIL oneshot_run: got crst=%b sw=%b want crst=0 sw=011", o_cnt_reset, o_sw);
        end
        tick(); tick();
        i_valid = 1'b1; step();
        total++;
        if (o_done !== 1'b1 || o_ticks !== 8'd3 || o_busy !== 1'b0 || o_sw !== 3'b010) begin
            bad++;
            $display("FAIL oneshot_third: got done=%b ticks=%0d busy=%b sw=%b want 1 3 0 010",
                     o_done, o_ticks, o_busy, o_sw);
        end
        i_valid = 1'b0; step();
        tick(); tick();
        total++;
        if (o_ticks !== 8'd3 || o_busy !== 1'b0 || o_sw[0] !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_after: got ticks=%0d busy=%b en=%b want 3 0 0", o_ticks, o_busy, o_sw[0]);
        end
        total++;
        if (done_cnt - d0 !== 1 || crst_cnt - c0 !== 1) begin
            bad++;
            $display("FAIL oneshot_pulses: got done=%0d crst=%0d want 1 1", done_cnt - d0, crst_cnt - c0);
        end
    endtask

    task automatic test_idle_ignore();
        i_pause = 1'b1; step();
        i_pause = 1'b0; i_stop = 1'b1; step();
        i_stop = 1'b0; step();
        total++;
        if (o_busy !== 1'b0 || o_sw !== 3'b010 || o_ticks !== 8'd3) begin
            bad++;
            $display("FAIL idle_ignore: got busy=%b sw=%b ticks=%0d want 0 010 3", o_busy, o_sw, o_ticks);
        end
    endtask

    task automatic test_pause();
        int d0;
        d0 = done_cnt;
        i_rate = 2'b10; i_oneshot = 1'b0; i_nticks = 8'd2; i_start = 1'b1; step();
        i_start = 1'b0; step();
        total++;
        if (o_ticks !== 8'd0 || o_sw !== 3'b101) begin
            bad++;
            $display("FAIL pause_start: got ticks=%0d sw=%b want 0 101", o_ticks, o_sw);
        end
        repeat (4) tick();
        total++;
        if (o_ticks !== 8'd4 || o_sw[0] !== 1'b1) begin
            bad++;
            $display("FAIL pause_run4: got ticks=%0d en=%b want 4 1", o_ticks, o_sw[0]);
        end
        i_pause = 1'b1; step();
        total++;
        if (o_sw[0] !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL pause_enter: got en=%b busy=%b want 0 1", o_sw[0], o_busy);
        end
        i_pause = 1'b0; step();
        tick(); tick();
        total++;
        if (o_ticks !== 8'd4 || o_sw[0] !== 1'b0) begin
            bad++;
            $display("FAIL pause_hold: got ticks=%0d en=%b want 4 0", o_ticks, o_sw[0]);
        end
        i_pause = 1'b1; step();
        total++;
        if (o_sw[0] !== 1'b1) begin
            bad++;
            $display("FAIL pause_resume: got en=%b want 1", o_sw[0]);
        end
        i_pause = 1'b0; step();
        tick();
        total++;
        if (o_ticks !== 8'd5 || o_sw !== 3'b101) begin
            bad++;
            $display("FAIL pause_final: got ticks=%0d sw=%b want 5 101", o_ticks, o_sw);
        end
        do_stop();
        total++;
        if (o_ticks !== 8'd5 || o_busy !== 1'b0 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL pause_stop: got ticks=%0d busy=%b done=%0d want 5 0 0", o_ticks, o_busy, done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        int d0;
        d0 = done_cnt;
        i_oneshot = 1'b0; i_start = 1'b1; step();
        i_start = 1'b0; step();
        repeat (255) tick();
        total++;
        if (o_ticks !== 8'd255) begin
            bad++;
            $display("FAIL wrap_255: got ticks=%0d want 255", o_ticks);
        end
        tick(); tick();
        total++;
        if (o_ticks !== 8'd1 || done_cnt - d0 !== 0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL wrap_257: got ticks=%0d done=%0d busy=%b want 1 0 1", o_ticks, done_cnt - d0, o_busy);
        end
        do_stop();
    endtask

    task automatic test_zero_target();
        int d0;
        d0 = done_cnt;
        i_oneshot = 1'b1; i_nticks = 8'd0; i_start = 1'b1; step();
        i_start = 1'b0; step();
        repeat (3) tick();
        total++;
        if (o_ticks !== 8'd3 || o_busy !== 1'b1 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL zero_target: got ticks=%0d busy=%b done=%0d want 3 1 0", o_ticks, o_busy, done_cnt - d0);
        end
        do_stop();
    endtask

    task automatic test_priority();
        i_oneshot = 1'b0; i_start = 1'b1; step();
        i_start = 1'b0; step();
        i_start = 1'b1; i_pause = 1'b1; i_stop = 1'b1; step();
        total++;
        if (o_busy !== 1'b0 || o_sw[0] !== 1'b0) begin
            bad++;
            $display("FAIL prio_run_all: got busy=%b en=%b want 0 0", o_busy, o_sw[0]);
        end
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0; step();
        i_start = 1'b1; i_pause = 1'b1; step();
        total++;
        if (o_busy !== 1'b1 || o_sw[0] !== 1'b1 || o_cnt_reset !== 1'b1) begin
            bad++;
            $display("FAIL prio_idle_sp: got busy=%b en=%b crst=%b want 1 1 1", o_busy, o_sw[0], o_cnt_reset);
        end
        i_start = 1'b0; i_pause = 1'b0; step();
        total++;
        if (o_sw[0] !== 1'b1) begin
            bad++;
            $display("FAIL prio_still_run: got en=%b want 1", o_sw[0]);
        end
        do_stop();
    endtask

    task automatic test_reset_mid_run();
        int c0;
        i_oneshot = 1'b0; i_rate = 2'b11; i_start = 1'b1; step();
        i_start = 1'b0; step();
        repeat (7) tick();
        total++;
        if (o_ticks !== 8'd7 || o_sw !== 3'b111) begin
            bad++;
            $display("FAIL rstmid_pre: got ticks=%0d sw=%b want 7 111", o_ticks, o_sw);
        end
        i_reset = 1'b1; i_start = 1'b1; step();
        total++;
        if ({o_sw, o_cnt_reset, o_busy, o_done, o_ticks} !== '0) begin
            bad++;
            $display("FAIL rstmid_clear: got sw=%b crst=%b busy=%b done=%b ticks=%0d want all 0",
                     o_sw, o_cnt_reset, o_busy, o_done, o_ticks);
        end
        step();
        c0 = crst_cnt;
        i_reset = 1'b0; step();
        total++;
        if (o_busy !== 1'b1 || o_cnt_reset !== 1'b1 || o_sw !== 3'b111) begin
            bad++;
            $display("FAIL rstmid_restart: got busy=%b crst=%b sw=%b want 1 1 111", o_busy, o_cnt_reset, o_sw);
        end
        i_start = 1'b0; step();
        total++;
        if (o_cnt_reset !== 1'b0 || o_ticks !== 8'd0 || crst_cnt - c0 !== 1) begin
            bad++;
            $display("FAIL rstmid_after: got crst=%b ticks=%0d pulses=%0d want 0 0 1",
                     o_cnt_reset, o_ticks, crst_cnt - c0);
        end
        do_stop();
    endtask

    task automatic test_stop_final_tick();
        int d0;
        d0 = done_cnt;
        i_oneshot = 1'b1; i_nticks = 8'd2; i_rate = 2'b00; i_start = 1'b1; step();
        i_start = 1'b0; step();
        tick();
        total++;
        if (o_ticks !== 8'd1 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL stopfin_first: got ticks=%0d busy=%b want 1 1", o_ticks, o_busy);
        end
        i_valid = 1'b1; i_stop = 1'b1; step();
        i_valid = 1'b0; i_stop = 1'b0; step();
        step();
        total++;
        if (o_ticks !== 8'd2 || o_busy !== 1'b0 || done_cnt - d0 !== 0) begin
            bad++;
            $display("FAIL stopfin_result: got ticks=%0d busy=%b done=%0d want 2 0 0", o_ticks, o_busy, done_cnt - d0);
        end
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0;
        i_rate = 2'b00; i_oneshot = 1'b0; i_nticks = '0; i_valid = 1'b0;
        test_reset();
        test_oneshot();
        test_idle_ignore();
        test_pause();
        test_wrap();
        test_zero_target();
        test_priority();
        test_reset_mid_run();
        test_stop_final_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
